// File: rtl/matrix_pkg.sv
// Shared constants and types for the ASCII matrix parser.
// Holds the character codes the parser recognises and the FSM state encoding.
package matrix_pkg;

  localparam int MAX_DIM = 5;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SKIP_WS = 3'd1,
    IN_NUM  = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CLS_SEP   = 2'd0,
    CLS_DIGIT = 2'd1,
    CLS_OTHER = 2'd2
  } byte_cls_t;

endpackage

// File: rtl/uart_matrix_parser.sv
// Parses a whitespace-separated decimal matrix arriving as a UART byte stream
// into a flat register array, row-major, one byte per element.
module uart_matrix_parser #(
  parameter int MAX_DIM    = matrix_pkg::MAX_DIM,
  parameter int MAX_DIGITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         parse_start,
  input  logic [2:0]                   rows,
  input  logic [2:0]                   cols,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [MAX_DIM*MAX_DIM*8-1:0] matrix_flat,
  output logic                         parse_busy,
  output logic                         parse_done,
  output logic                         parse_error
);

  import matrix_pkg::*;

  localparam int DCW = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0] DIG_MAX = DCW'(MAX_DIGITS);
  localparam logic [2:0]     DIM3    = 3'(MAX_DIM);
  localparam logic [7:0]     DIM8    = 8'(MAX_DIM);

  function automatic byte_cls_t classify(input logic [7:0] b);
    if (b == ASCII_SPACE || b == ASCII_CR || b == ASCII_LF) begin
      return CLS_SEP;
    end else if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
      return CLS_DIGIT;
    end else begin
      return CLS_OTHER;
    end
  endfunction

  state_t                       state_r, state_s;
  logic [2:0]                   rows_r, rows_s, cols_r, cols_s;
  logic [2:0]                   row_r, row_s, col_r, col_s;
  logic [7:0]                   acc_r, acc_s;
  logic [DCW-1:0]               dcnt_r, dcnt_s;
  logic [MAX_DIM*MAX_DIM*8-1:0] matrix_r, matrix_s;
  logic                         busy_r, busy_s, done_r, done_s, error_r, error_s;

  byte_cls_t   cls_s;
  logic [7:0]  digit_s;
  logic [7:0]  elem_idx_s;
  logic [10:0] elem_off_s;
  logic        last_col_s, last_row_s, dims_bad_s;

  assign cls_s      = classify(rx_data);
  assign digit_s    = rx_data - ASCII_ZERO;
  assign elem_idx_s = ({5'd0, row_r} * DIM8) + {5'd0, col_r};
  assign elem_off_s = {elem_idx_s, 3'b000};
  assign last_col_s = (col_r == cols_r - 3'd1);
  assign last_row_s = (row_r == rows_r - 3'd1);
  assign dims_bad_s = (rows == 3'd0) || (rows > DIM3) || (cols == 3'd0) || (cols > DIM3);

  // State and datapath registers; reset discards any parse in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rows_r   <= 3'd0;
      cols_r   <= 3'd0;
      row_r    <= 3'd0;
      col_r    <= 3'd0;
      acc_r    <= 8'd0;
      dcnt_r   <= '0;
      matrix_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      rows_r   <= rows_s;
      cols_r   <= cols_s;
      row_r    <= row_s;
      col_r    <= col_s;
      acc_r    <= acc_s;
      dcnt_r   <= dcnt_s;
      matrix_r <= matrix_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      error_r  <= error_s;
    end
  end

  // Next-state and datapath update; every register holds unless a branch says otherwise.
  always_comb begin
    state_s  = state_r;
    rows_s   = rows_r;
    cols_s   = cols_r;
    row_s    = row_r;
    col_s    = col_r;
    acc_s    = acc_r;
    dcnt_s   = dcnt_r;
    matrix_s = matrix_r;
    busy_s   = busy_r;
    done_s   = done_r;
    error_s  = error_r;

    case (state_r)
      IDLE: begin
        if (parse_start) begin
          rows_s   = rows;
          cols_s   = cols;
          row_s    = 3'd0;
          col_s    = 3'd0;
          acc_s    = 8'd0;
          dcnt_s   = '0;
          matrix_s = '0;
          done_s   = 1'b0;
          if (dims_bad_s) begin
            state_s = ERR;
            error_s = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = SKIP_WS;
            error_s = 1'b0;
            busy_s  = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      SKIP_WS: begin
        if (rx_valid) begin
          case (cls_s)
            CLS_SEP: state_s = SKIP_WS;
            CLS_DIGIT: begin
              acc_s   = digit_s;
              dcnt_s  = DCW'(1);
              state_s = IN_NUM;
            end
            default: begin
              state_s = ERR;
              error_s = 1'b1;
              busy_s  = 1'b0;
            end
          endcase
        end else begin
          state_s = SKIP_WS;
        end
      end

      IN_NUM: begin
        if (rx_valid) begin
          case (cls_s)
            CLS_DIGIT: begin
              if (dcnt_r == DIG_MAX) begin
                state_s = ERR;
                error_s = 1'b1;
                busy_s  = 1'b0;
              end else begin
                acc_s  = (acc_r * 8'd10) + digit_s;
                dcnt_s = dcnt_r + DCW'(1);
              end
            end
            CLS_SEP: begin
              matrix_s[elem_off_s +: 8] = acc_r;
              // Row boundaries are implicit: the column index simply wraps.
              if (last_col_s) begin
                col_s = 3'd0;
                row_s = row_r + 3'd1;
              end else begin
                col_s = col_r + 3'd1;
              end
              if (last_col_s && last_row_s) begin
                state_s = DONE;
                done_s  = 1'b1;
                busy_s  = 1'b0;
              end else begin
                state_s = SKIP_WS;
              end
            end
            default: begin
              state_s = ERR;
              error_s = 1'b1;
              busy_s  = 1'b0;
            end
          endcase
        end else begin
          state_s = IN_NUM;
        end
      end

      DONE, ERR: begin
        if (!parse_start) begin
          state_s = IDLE;
        end else begin
          state_s = state_r;
        end
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign matrix_flat = matrix_r;
  assign parse_busy  = busy_r;
  assign parse_done  = done_r;
  assign parse_error = error_r;

endmodule

// File: tb/tb_uart_matrix_parser.sv
// Directed self-checking bench for uart_matrix_parser.
module tb_uart_matrix_parser;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         parse_start = 1'b0;
  logic [2:0]   rows = 3'd0;
  logic [2:0]   cols = 3'd0;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic [199:0] matrix_flat;
  logic         parse_busy, parse_done, parse_error;

  int n_checks = 0;
  int n_fail   = 0;

  uart_matrix_parser dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .parse_start (parse_start),
    .rows        (rows),
    .cols        (cols),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .matrix_flat (matrix_flat),
    .parse_busy  (parse_busy),
    .parse_done  (parse_done),
    .parse_error (parse_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] elem(input int r, input int c);
    return matrix_flat[(r*5+c)*8 +: 8];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic start(input logic [2:0] r, input logic [2:0] c, input bit hold);
    @(negedge clk);
    rows        = r;
    cols        = c;
    parse_start = 1'b1;
    @(negedge clk);
    if (!hold) parse_start = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", parse_busy, 1'b0);
    chk("reset_done", parse_done, 1'b0);
    chk("reset_error", parse_error, 1'b0);
    chk("reset_flat", |matrix_flat, 1'b0);
    rst_n = 1'b1;

    // 2x2 parse, parse_start held and dims changed while busy
    start(3'd2, 3'd2, 1'b1);
    chk("s1_busy", parse_busy, 1'b1);
    rows = 3'd1;
    cols = 3'd1;
    send_str("12 07\n03 99");
    chk("s1_no_early_done", parse_done, 1'b0);
    chk("s1_busy_mid", parse_busy, 1'b1);
    send_str("\n");
    chk("s1_done", parse_done, 1'b1);
    chk("s1_busy_end", parse_busy, 1'b0);
    chk("s1_error", parse_error, 1'b0);
    chk("s1_e00", elem(0, 0), 8'd12);
    chk("s1_e01", elem(0, 1), 8'd7);
    chk("s1_e10", elem(1, 0), 8'd3);
    chk("s1_e11", elem(1, 1), 8'd99);
    send_str("5 ");
    chk("s1_drop_e00", elem(0, 0), 8'd12);
    chk("s1_done_hold", parse_done, 1'b1);
    parse_start = 1'b0;
    @(negedge clk);
    chk("s1_done_idle", parse_done, 1'b1);

    // 1x3 parse with mixed whitespace
    start(3'd1, 3'd3, 1'b0);
    chk("s2_done_cleared", parse_done, 1'b0);
    chk("s2_e10_zeroed", elem(1, 0), 8'd0);
    send_str(" 5\r\n 40  1");
    chk("s2_no_early_done", parse_done, 1'b0);
    send_str(" ");
    chk("s2_done", parse_done, 1'b1);
    chk("s2_e00", elem(0, 0), 8'd5);
    chk("s2_e01", elem(0, 1), 8'd40);
    chk("s2_e02", elem(0, 2), 8'd1);

    // three-digit number overflows the digit limit
    start(3'd1, 3'd2, 1'b0);
    send_str("12");
    chk("s3_no_err_yet", parse_error, 1'b0);
    send_str("3");
    chk("s3_error", parse_error, 1'b1);
    chk("s3_busy", parse_busy, 1'b0);
    chk("s3_e00", elem(0, 0), 8'd0);

    // illegal byte keeps partial result
    start(3'd2, 3'd2, 1'b0);
    chk("s4_err_cleared", parse_error, 1'b0);
    send_str("1 x");
    chk("s4_error", parse_error, 1'b1);
    chk("s4_done", parse_done, 1'b0);
    chk("s4_e00", elem(0, 0), 8'd1);

    // bad dimensions and the largest legal ones
    start(3'd0, 3'd3, 1'b0);
    chk("s5_rows0_err", parse_error, 1'b1);
    chk("s5_rows0_busy", parse_busy, 1'b0);
    start(3'd3, 3'd6, 1'b0);
    chk("s5_cols6_err", parse_error, 1'b1);
    start(3'd5, 3'd5, 1'b0);
    chk("s5_5x5_err", parse_error, 1'b0);
    chk("s5_5x5_busy", parse_busy, 1'b1);
    send_str("x");
    chk("s5_abort", parse_error, 1'b1);

    // reset mid-parse, then a fresh parse
    start(3'd3, 3'd3, 1'b0);
    send_str("4 8 ");
    chk("s6_e01", elem(0, 1), 8'd8);
    #3 rst_n = 1'b0;
    #1;
    chk("s6_rst_busy", parse_busy, 1'b0);
    chk("s6_rst_flat", |matrix_flat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s6_post_busy", parse_busy, 1'b0);
    chk("s6_post_done", parse_done, 1'b0);
    chk("s6_post_error", parse_error, 1'b0);
    start(3'd1, 3'd1, 1'b0);
    send_str("7\n");
    chk("s6_fresh_done", parse_done, 1'b1);
    chk("s6_fresh_e00", elem(0, 0), 8'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
